dvfs_actuator: RTL and testbench
================================

DVFS_ACTUATOR -- requirements
Module: dvfs_actuator

Interface
REQ-001 Parameter VSETTLE, default 16: cycles a new voltage level is held before the next step; legal range 1..256.
REQ-002 Parameter FSETTLE, default 4: cycles a new frequency level is held before the next step; legal range 1..256.
REQ-003 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  a requested level pair is present.
REQ-007 voltage_level  input  2  requested voltage level, 00 lowest .. 11 highest.
REQ-008 frequency_level  input  2  requested frequency level, 00 lowest .. 11 highest.
REQ-009 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-010 vdd_sel  output  2  voltage level currently applied to the regulator.
REQ-011 clk_sel  output  2  frequency level currently applied to the clock generator.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a request completes.
REQ-014 err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-015 Handshake: a request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; voltage_level and frequency_level SHALL be captured on that edge; inputs are ignored at all other times.
REQ-016 States SHALL be IDLE, V_UP, F_CHG, V_DN, DONE.
REQ-017 Rejection: an accepted request with frequency_level > voltage_level SHALL leave vdd_sel and clk_sel unchanged, stay in IDLE, and pulse err for the one cycle after the accepting edge.
REQ-018 Ordering: voltage SHALL rise before frequency changes, and voltage SHALL fall only after frequency changes; clk_sel > vdd_sel SHALL never be observable.
REQ-019 On the accepting edge, next state SHALL be the first applicable of: V_UP if target_v > vdd_sel; F_CHG if target_f != clk_sel; V_DN if target_v < vdd_sel; otherwise DONE.
REQ-020 Entering V_UP or V_DN SHALL load vdd_sel = target_v on the entry edge and load the settle counter with VSETTLE-1.
REQ-021 Entering F_CHG SHALL load clk_sel = target_f on the entry edge and load the settle counter with FSETTLE-1.
REQ-022 The settle counter SHALL be 8 bits and decrement each cycle; a settle state SHALL exit on the edge where the counter is 0, so it lasts exactly VSETTLE or FSETTLE cycles.
REQ-023 From V_UP, next state SHALL be F_CHG if target_f != clk_sel, else DONE; from F_CHG, V_DN if target_v < vdd_sel, else DONE; from V_DN, DONE.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 A request equal to the current (vdd_sel, clk_sel) SHALL go directly to DONE, with done high in the cycle after acceptance.
REQ-026 Total latency from accepting edge to done SHALL be (VSETTLE if voltage changes) + (FSETTLE if frequency changes) cycles, and 1 cycle when neither changes.
REQ-027 req_valid held high in DONE SHALL NOT be accepted until the IDLE cycle that follows.

Reset
REQ-028 rst=1 on a rising edge SHALL force IDLE, vdd_sel=00, clk_sel=00, counter=0, and busy, done and err to 0.
REQ-029 After that edge, req_ready SHALL be 1.
REQ-030 Reset SHALL take priority over any in-progress transition and over a simultaneous request.

Verification
REQ-031 Raise, with VSETTLE=16 and FSETTLE=4: from 00/00, request 11/11 accepted at edge 0 -> vdd_sel=11 after edge 0, clk_sel=11 after edge 16, done high in the cycle after edge 20, req_ready high after edge 21.
REQ-032 Lower: from 11/11, request 01/00 -> clk_sel=00 after the accept edge, vdd_sel=01 exactly 4 cycles later, done 16 cycles after that, and clk_sel<=vdd_sel on every cycle.
REQ-033 Reject: request 01/10 -> err pulse for one cycle, outputs unchanged, busy stays 0, done stays 0.
REQ-034 No change: request equal to the current levels -> done in the next cycle, vdd_sel and clk_sel unchanged.
REQ-035 Reset mid-operation: assert rst during V_UP of a 00/00->11/11 request -> vdd_sel=00, clk_sel=00, IDLE on the next edge, no done pulse.
REQ-036 Back-to-back: req_valid held high continuously -> exactly one acceptance per IDLE visit, and no request is accepted while busy=1.

Source files
------------

// File: rtl/dvfs_actuator.sv
// dvfs_actuator
//   Sequences voltage and frequency changes for one power domain so the
//   clock is never faster than the supply can sustain. Voltage rises before
//   frequency changes, and voltage falls only after frequency has changed.
//   Each applied level is held for a settle time before the next step.
//
// Parameters
//   VSETTLE          cycles a new voltage level is held (1..256)
//   FSETTLE          cycles a new frequency level is held (1..256)
// Ports
//   clk              sole clock, rising edge
//   rst              synchronous active-high reset
//   req_valid        a requested level pair is present
//   voltage_level    requested voltage level (0 lowest .. 3 highest)
//   frequency_level  requested frequency level (0 lowest .. 3 highest)
//   req_ready        high only in IDLE; request accepted when valid & ready
//   vdd_sel          voltage level applied to the regulator
//   clk_sel          frequency level applied to the clock generator
//   busy             high in every state except IDLE
//   done             one-cycle pulse when a request completes
//   err              one-cycle pulse after a rejected request
module dvfs_actuator #(
  parameter int VSETTLE = 16,
  parameter int FSETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] voltage_level,
  input  logic [1:0] frequency_level,
  output logic       req_ready,
  output logic [1:0] vdd_sel,
  output logic [1:0] clk_sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    V_UP  = 3'd1,
    F_CHG = 3'd2,
    V_DN  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] VLOAD = 8'(VSETTLE - 1);
  localparam logic [7:0] FLOAD = 8'(FSETTLE - 1);

  state_t     state;
  state_t     next_state;
  logic [1:0] target_v;
  logic [1:0] target_f;
  logic [7:0] cnt;
  logic       accept;
  logic       reject;
  logic       load_v;
  logic       load_f;
  logic [1:0] new_v;
  logic [1:0] new_f;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode. In IDLE the targets come straight from the inputs,
  // because the captured copies are only valid one cycle later.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    reject     = 1'b0;
    load_v     = 1'b0;
    load_f     = 1'b0;
    new_v      = target_v;
    new_f      = target_f;
    case (state)
      IDLE: begin
        new_v  = voltage_level;
        new_f  = frequency_level;
        accept = req_valid;
        if (req_valid) begin
          if (frequency_level > voltage_level) begin
            reject = 1'b1;
          end else if (voltage_level > vdd_sel) begin
            next_state = V_UP;
            load_v     = 1'b1;
          end else if (frequency_level != clk_sel) begin
            next_state = F_CHG;
            load_f     = 1'b1;
          end else if (voltage_level < vdd_sel) begin
            next_state = V_DN;
            load_v     = 1'b1;
          end else begin
            next_state = DONE;
          end
        end
      end
      V_UP: begin
        if (cnt == 8'd0) begin
          if (target_f != clk_sel) begin
            next_state = F_CHG;
            load_f     = 1'b1;
          end else begin
            next_state = DONE;
          end
        end
      end
      F_CHG: begin
        if (cnt == 8'd0) begin
          if (target_v < vdd_sel) begin
            next_state = V_DN;
            load_v     = 1'b1;
          end else begin
            next_state = DONE;
          end
        end
      end
      V_DN: begin
        if (cnt == 8'd0) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: applied levels, captured targets, settle counter, err pulse.
  // A rejected request still overwrites the targets; they are never used
  // because the FSM stays in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      vdd_sel  <= 2'd0;
      clk_sel  <= 2'd0;
      target_v <= 2'd0;
      target_f <= 2'd0;
      cnt      <= 8'd0;
      err      <= 1'b0;
    end else begin
      err <= reject;
      if (accept) begin
        target_v <= voltage_level;
        target_f <= frequency_level;
      end
      if (load_v) vdd_sel <= new_v;
      if (load_f) clk_sel <= new_f;
      if (load_v)           cnt <= VLOAD;
      else if (load_f)      cnt <= FLOAD;
      else if (cnt != 8'd0) cnt <= cnt - 8'd1;
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_dvfs_actuator.sv
// tb_dvfs_actuator
//   Directed testbench for dvfs_actuator with VSETTLE=16, FSETTLE=4.
//   Each scenario task drives stimulus and compares outputs against
//   hand-computed values, sampled 1 time unit after the rising edge.
module tb_dvfs_actuator;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [1:0] voltage_level;
  logic [1:0] frequency_level;
  logic       req_ready;
  logic [1:0] vdd_sel;
  logic [1:0] clk_sel;
  logic       busy;
  logic       done;
  logic       err;

  int n_compared;
  int n_mismatched;

  dvfs_actuator #(.VSETTLE(16), .FSETTLE(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .voltage_level   (voltage_level),
    .frequency_level (frequency_level),
    .req_ready       (req_ready),
    .vdd_sel         (vdd_sel),
    .clk_sel         (clk_sel),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [1:0] v, input logic [1:0] f);
    req_valid       = 1'b1;
    voltage_level   = v;
    frequency_level = f;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1;
    voltage_level = 2'd3;
    frequency_level = 2'd3;
    tick();
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    n_compared++;
    if ({vdd_sel, clk_sel} !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_levels: got %b/%b expected 00/00", vdd_sel, clk_sel);
    end
    n_compared++;
    if ({req_ready, busy, done, err} !== 4'b1000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_flags: got rdy/busy/done/err=%b expected 1000",
               {req_ready, busy, done, err});
    end
  endtask

  task automatic test_raise();
    request(2'd3, 2'd3);
    tick();
    req_valid = 1'b0;
    n_compared++;
    if ({vdd_sel, clk_sel, busy, req_ready} !== 6'b11_00_1_0) begin
      n_mismatched++;
      $display("[TB] FAIL raise_edge0: got vdd=%b clk=%b busy=%b rdy=%b expected 11 00 1 0",
               vdd_sel, clk_sel, busy, req_ready);
    end
    for (int k = 1; k <= 21; k++) begin
      tick();
      n_compared++;
      if (clk_sel > vdd_sel) begin
        n_mismatched++;
        $display("[TB] FAIL raise_order: edge %0d clk=%0d vdd=%0d expected clk<=vdd", k, clk_sel, vdd_sel);
      end
      if (k == 15 || k == 16) begin
        n_compared++;
        if (clk_sel !== ((k == 16) ? 2'd3 : 2'd0)) begin
          n_mismatched++;
          $display("[TB] FAIL raise_clk: edge %0d got %0d expected %0d", k, clk_sel, (k == 16) ? 3 : 0);
        end
      end
      if (k >= 19) begin
        n_compared++;
        if (done !== (k == 20)) begin
          n_mismatched++;
          $display("[TB] FAIL raise_done: edge %0d got %b expected %b", k, done, (k == 20));
        end
      end
      if (k == 21) begin
        n_compared++;
        if ({req_ready, busy} !== 2'b10) begin
          n_mismatched++;
          $display("[TB] FAIL raise_ready: got rdy=%b busy=%b expected 1 0", req_ready, busy);
        end
      end
    end
  endtask

  task automatic test_lower();
    request(2'd1, 2'd0);
    tick();
    req_valid = 1'b0;
    n_compared++;
    if ({vdd_sel, clk_sel} !== 4'b11_00) begin
      n_mismatched++;
      $display("[TB] FAIL lower_edge0: got %b/%b expected 11/00", vdd_sel, clk_sel);
    end
    for (int k = 1; k <= 21; k++) begin
      tick();
      n_compared++;
      if (clk_sel > vdd_sel) begin
        n_mismatched++;
        $display("[TB] FAIL lower_order: edge %0d clk=%0d vdd=%0d expected clk<=vdd", k, clk_sel, vdd_sel);
      end
      if (k == 3 || k == 4) begin
        n_compared++;
        if (vdd_sel !== ((k == 4) ? 2'd1 : 2'd3)) begin
          n_mismatched++;
          $display("[TB] FAIL lower_vdd: edge %0d got %0d expected %0d", k, vdd_sel, (k == 4) ? 1 : 3);
        end
      end
      if (k >= 19) begin
        n_compared++;
        if (done !== (k == 20)) begin
          n_mismatched++;
          $display("[TB] FAIL lower_done: edge %0d got %b expected %b", k, done, (k == 20));
        end
      end
    end
  endtask

  task automatic test_reject();
    request(2'd1, 2'd2);
    tick();
    req_valid = 1'b0;
    n_compared++;
    if ({err, busy, done, req_ready, vdd_sel, clk_sel} !== 8'b1_0_0_1_01_00) begin
      n_mismatched++;
      $display("[TB] FAIL reject_pulse: got err=%b busy=%b done=%b rdy=%b vdd=%b clk=%b expected 1 0 0 1 01 00",
               err, busy, done, req_ready, vdd_sel, clk_sel);
    end
    tick();
    n_compared++;
    if ({err, busy, done, vdd_sel, clk_sel} !== 7'b0_0_0_01_00) begin
      n_mismatched++;
      $display("[TB] FAIL reject_after: got err=%b busy=%b done=%b vdd=%b clk=%b expected 0 0 0 01 00",
               err, busy, done, vdd_sel, clk_sel);
    end
  endtask

  task automatic test_no_change();
    request(2'd1, 2'd0);
    tick();
    req_valid = 1'b0;
    n_compared++;
    if ({done, busy, vdd_sel, clk_sel} !== 6'b1_1_01_00) begin
      n_mismatched++;
      $display("[TB] FAIL nochange_done: got done=%b busy=%b vdd=%b clk=%b expected 1 1 01 00",
               done, busy, vdd_sel, clk_sel);
    end
    tick();
    n_compared++;
    if ({done, req_ready} !== 2'b01) begin
      n_mismatched++;
      $display("[TB] FAIL nochange_idle: got done=%b rdy=%b expected 0 1", done, req_ready);
    end
  endtask

  task automatic test_mid_reset();
    int dones;
    request(2'd3, 2'd3);
    tick();
    tick();
    tick();
    n_compared++;
    if ({busy, vdd_sel, clk_sel} !== 5'b1_11_00) begin
      n_mismatched++;
      $display("[TB] FAIL midrst_vup: got busy=%b vdd=%b clk=%b expected 1 11 00", busy, vdd_sel, clk_sel);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    n_compared++;
    if ({vdd_sel, clk_sel, busy, req_ready, done} !== 7'b00_00_0_1_0) begin
      n_mismatched++;
      $display("[TB] FAIL midrst_state: got vdd=%b clk=%b busy=%b rdy=%b done=%b expected 00 00 0 1 0",
               vdd_sel, clk_sel, busy, req_ready, done);
    end
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done) dones++;
    end
    n_compared++;
    if (dones !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL midrst_nodone: got %0d done pulses expected 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int accepts;
    int dones;
    int overlap;
    accepts = 0;
    dones = 0;
    overlap = 0;
    request(2'd1, 2'd1);
    for (int k = 0; k < 40; k++) begin
      if (req_valid && req_ready) accepts++;
      if (req_ready && busy) overlap++;
      tick();
      if (done) dones++;
    end
    req_valid = 1'b0;
    n_compared++;
    if (accepts !== 10) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_accepts: got %0d expected 10", accepts);
    end
    n_compared++;
    if (dones !== 10) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_dones: got %0d expected 10", dones);
    end
    n_compared++;
    if (overlap !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_ready_busy: got %0d overlapping cycles expected 0", overlap);
    end
    n_compared++;
    if ({vdd_sel, clk_sel, req_ready} !== 5'b01_01_1) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_final: got vdd=%b clk=%b rdy=%b expected 01 01 1", vdd_sel, clk_sel, req_ready);
    end
  endtask

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    rst = 1'b0;
    req_valid = 1'b0;
    voltage_level = 2'd0;
    frequency_level = 2'd0;
    #2;
    test_reset();
    test_raise();
    test_lower();
    test_reject();
    test_no_change();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
